fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the program counter and drives the address into the combinational instruction memory.
- Captures the returned word into the IF/ID pipeline register for decode.
- Handles load-use stalls, taken-branch/jump redirects from ID, end-of-program detection and misaligned-target trapping.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IMEM_LIMIT, 32'd68, first byte address past the end of the program; fetch at or beyond it stops the stage
NOP_WORD, 32'h0000_0000, word injected into IF/ID on bubbles

Ports:
clk  input  1  clock, rising-edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard unit: hold PC and IF/ID this cycle
br_taken  input  1  ID: branch resolved taken
br_target  input  32  ID: branch target byte address
jump  input  1  ID: unconditional jump
jump_target  input  32  ID: jump target byte address
inst_addr  output  32  byte address to instruction memory (= pc, combinational)
inst_data  input  32  instruction word returned combinationally for inst_addr
if_id_instr  output  32  registered instruction to decode
if_id_pc4  output  32  registered pc+4 of that instruction
if_id_valid  output  1  IF/ID holds a real instruction
fetch_done  output  1  stage in DONE state
misalign_err  output  1  sticky: redirect target had addr[1:0]!=0
fetch_count  output  32  number of valid instructions delivered to IF/ID, saturating

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, if_id_instr=NOP_WORD, if_id_pc4=0, if_id_valid=0, fetch_done=0, misalign_err=0, fetch_count=0, state=RUN.
- Latency: inst_addr=pc same cycle; word appears on if_id_instr one rising edge later.
- States: RUN, DONE, HALT (encoding free; fetch_done=1 only in DONE).
- Redirect: redir = br_taken | jump. Target = br_target if br_taken, else jump_target (branch priority when both asserted).
- Per-edge priority, highest first:
  1. stall=1: pc, IF/ID, fetch_count, state all hold. Redirect is ignored; ID re-presents it next cycle.
  2. state=HALT: everything holds except IF/ID becomes bubble (instr=NOP_WORD, pc4=0, valid=0). HALT is left only by reset.
  3. redir=1 with target[1:0]!=0: misalign_err<=1, state<=HALT, IF/ID bubble, pc unchanged.
  4. redir=1, aligned: pc<=target, IF/ID bubble (flush of the wrong-path fetch).
     - From DONE, an aligned target below IMEM_LIMIT returns state to RUN.
     - A target at or above IMEM_LIMIT moves state to DONE.
  5. state=RUN, pc<IMEM_LIMIT: if_id_instr<=inst_data, if_id_pc4<=pc+4, if_id_valid<=1, pc<=pc+4, fetch_count+=1 (saturate at 32'hFFFF_FFFF).
  6. state=RUN, pc>=IMEM_LIMIT: state<=DONE, IF/ID bubble, pc holds.
  7. state=DONE, no redirect: IF/ID bubble, pc holds.
- In DONE/HALT inst_data is never captured; the memory is undefined past its last word.
- pc+4 wraps modulo 2^32 with no flag.
- fetch_count counts only edges taking rule 5.
- Reset asserted mid-stall or mid-redirect overrides everything immediately.

Test Plan:
- Reset release, no stall/redirect, memory loaded with program at 0..64 -> after edge 1: if_id_instr=32'h20020005, if_id_pc4=4, valid=1, inst_addr=4. After edge 3: if_id_instr=32'h20070003, fetch_count=3.
- stall=1 for 2 cycles while pc=16 -> inst_addr stays 16, if_id_instr stays 32'h00e22025, fetch_count unchanged. Release -> next edge loads 32'h00642824, pc4=20.
- br_taken=1, br_target=32'h24 while pc=28 -> next edge: valid=0, instr=0, inst_addr=0x24. Following edge: if_id_instr=32'h20050000, pc4=0x28.
- Run straight to pc=68 -> edge at pc=68 sets fetch_done=1, valid=0, inst_addr holds 68. Then jump=1, jump_target=0 -> state RUN, fetch_done=0, next fetch 32'h20020005.
- br_taken=1, jump=1, br_target=8, jump_target=12 -> pc=8 (branch priority). With stall=1 on the same cycle -> pc unchanged, no flush.
- jump=1, jump_target=32'h0000_0006 -> misalign_err=1, stage frozen with valid=0 for 10+ cycles despite further redirects. rst_n pulse -> all outputs back to reset values.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, feeds the combinational instruction
// memory and registers the fetched word into the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] IMEM_LIMIT = 32'd68,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_done,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DONE = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;
    logic        r_misalign;
    logic [31:0] r_count;

    logic        w_redir;
    logic [31:0] w_target;
    logic        w_misaligned;
    logic [31:0] w_pc_plus4;

    // Branch wins over jump when ID asserts both in the same cycle.
    assign w_redir      = br_taken | jump;
    assign w_target     = br_taken ? br_target : jump_target;
    assign w_misaligned = (w_target[1:0] != 2'b00);
    assign w_pc_plus4   = r_pc + 32'd4;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before this edge, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_instr    <= NOP_WORD;
            r_pc4      <= 32'd0;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
            r_count    <= 32'd0;
        end else if (!stall) begin
            // NOTE: bubble is the default; only a real fetch overrides IF/ID.
            r_instr <= NOP_WORD;
            r_pc4   <= 32'd0;
            r_valid <= 1'b0;
            if (r_state == HALT) begin
                r_state <= HALT;
            end else if (w_redir && w_misaligned) begin
                r_misalign <= 1'b1;
                r_state    <= HALT;
            end else if (w_redir) begin
                r_pc    <= w_target;
                r_state <= (w_target >= IMEM_LIMIT) ? DONE : RUN;
            end else if (r_state == RUN && r_pc < IMEM_LIMIT) begin
                r_instr <= inst_data;
                r_pc4   <= w_pc_plus4;
                r_valid <= 1'b1;
                r_pc    <= w_pc_plus4;
                if (r_count != 32'hFFFF_FFFF) begin
                    r_count <= r_count + 32'd1;
                end
            end else begin
                // Walked off the end of the program, or idling in DONE.
                r_state <= DONE;
            end
        end
    end

    assign inst_addr    = r_pc;
    assign if_id_instr  = r_instr;
    assign if_id_pc4    = r_pc4;
    assign if_id_valid  = r_valid;
    assign fetch_done   = (r_state == DONE);
    assign misalign_err = r_misalign;
    assign fetch_count  = r_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed test-plan steps followed by
// randomized stall/redirect/reset traffic, all checked against a rule-level model.
module tb_fetch_stage;

    localparam logic [31:0] LIMIT = 32'd68;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] OOB   = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_done;
    logic        misalign_err;
    logic [31:0] fetch_count;

    fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_LIMIT(LIMIT),
        .NOP_WORD  (NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jump        (jump),
        .jump_target (jump_target),
        .inst_addr   (inst_addr),
        .inst_data   (inst_data),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .fetch_done  (fetch_done),
        .misalign_err(misalign_err),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:16];

    function automatic logic [31:0] imem(input logic [31:0] addr);
        logic [31:0] idx;
        idx = addr >> 2;
        if (addr < LIMIT) return mem[idx[4:0]];
        return OOB;
    endfunction

    always_comb inst_data = imem(inst_addr);

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: the architectural view of the stage.
    logic [31:0] m_pc, m_instr, m_pc4, m_count;
    logic        m_valid, m_done, m_halt, m_mis;

    task automatic model_reset();
        m_pc = 32'd0; m_instr = NOP; m_pc4 = 32'd0; m_count = 32'd0;
        m_valid = 1'b0; m_done = 1'b0; m_halt = 1'b0; m_mis = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic br, input logic [31:0] bt,
                              input logic jp, input logic [31:0] jt);
        logic [31:0] tgt;
        tgt = br ? bt : jt;
        if (st) return;
        m_instr = NOP; m_pc4 = 32'd0; m_valid = 1'b0;
        if (m_halt) begin
            // frozen until reset
        end else if ((br || jp) && (tgt % 4 != 0)) begin
            m_mis = 1'b1; m_halt = 1'b1; m_done = 1'b0;
        end else if (br || jp) begin
            m_pc = tgt;
            m_done = (tgt >= LIMIT);
        end else if (!m_done && m_pc < LIMIT) begin
            m_instr = imem(m_pc);
            m_pc4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
        end else begin
            m_done = 1'b1;
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".inst_addr"}, inst_addr, m_pc);
        check({where, ".instr"}, if_id_instr, m_instr);
        check({where, ".pc4"}, if_id_pc4, m_pc4);
        check({where, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
        check({where, ".done"}, {31'd0, fetch_done}, {31'd0, m_done & ~m_halt});
        check({where, ".misalign"}, {31'd0, misalign_err}, {31'd0, m_mis});
        check({where, ".count"}, fetch_count, m_count);
    endtask

    // One clock: drive inputs away from the edge, advance model, compare after edge.
    task automatic cycle(input logic st, input logic br, input logic [31:0] bt,
                         input logic jp, input logic [31:0] jt);
        stall = st; br_taken = br; br_target = bt; jump = jp; jump_target = jt;
        model_step(st, br, bt, jp, jt);
        @(posedge clk);
        #1;
        check_all("cyc");
        stall = 1'b0; br_taken = 1'b0; jump = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        mem[0]  = 32'h20020005; mem[1]  = 32'h2003000c; mem[2]  = 32'h20070003;
        mem[3]  = 32'h00e22025; mem[4]  = 32'h00642824; mem[5]  = 32'h00a42820;
        mem[6]  = 32'h10a7000a; mem[7]  = 32'h0064202a; mem[8]  = 32'h10800001;
        mem[9]  = 32'h20050000; mem[10] = 32'h00e2202a; mem[11] = 32'h00853820;
        mem[12] = 32'h00e23822; mem[13] = 32'hac670044; mem[14] = 32'h8c020050;
        mem[15] = 32'h08000011; mem[16] = 32'h20020001;
        n_checks = 0; n_errors = 0;
        stall = 1'b0; br_taken = 1'b0; jump = 1'b0; br_target = 32'd0; jump_target = 32'd0;
        rst_n = 1'b0;
        model_reset();
        #12;
        check_all("init");
        @(negedge clk);
        rst_n = 1'b1;

        // Straight-line fetch from reset.
        idle();
        check("e1.instr", if_id_instr, 32'h20020005);
        check("e1.pc4", if_id_pc4, 32'd4);
        check("e1.addr", inst_addr, 32'd4);
        idle(); idle();
        check("e3.instr", if_id_instr, 32'h20070003);
        check("e3.count", fetch_count, 32'd3);
        idle();

        // Stall two cycles at pc=16.
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        check("stall.addr", inst_addr, 32'd16);
        check("stall.instr", if_id_instr, 32'h00e22025);
        check("stall.count", fetch_count, 32'd4);
        idle();
        check("rel.instr", if_id_instr, 32'h00642824);
        check("rel.pc4", if_id_pc4, 32'd20);

        // Taken branch at pc=28 to 0x24.
        idle(); idle();
        check("pre_br.addr", inst_addr, 32'd28);
        cycle(1'b0, 1'b1, 32'h24, 1'b0, 32'd0);
        check("br.valid", {31'd0, if_id_valid}, 32'd0);
        check("br.instr", if_id_instr, 32'd0);
        check("br.addr", inst_addr, 32'h24);
        idle();
        check("br2.instr", if_id_instr, 32'h20050000);
        check("br2.pc4", if_id_pc4, 32'h28);

        // Run off the end of the program.
        begin
            int budget;
            budget = 0;
            while (!fetch_done && budget < 40) begin
                idle();
                budget++;
            end
            check("done_timeout", {31'd0, fetch_done}, 32'd1);
        end
        check("done.addr", inst_addr, 32'd68);
        check("done.valid", {31'd0, if_id_valid}, 32'd0);
        idle();
        check("done_hold.addr", inst_addr, 32'd68);
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'd0);
        check("restart.done", {31'd0, fetch_done}, 32'd0);
        idle();
        check("restart.instr", if_id_instr, 32'h20020005);

        // Branch and jump together, first under stall, then live.
        idle();
        cycle(1'b1, 1'b1, 32'd8, 1'b1, 32'd12);
        check("both_stall.addr", inst_addr, 32'd8);
        check("both_stall.valid", {31'd0, if_id_valid}, 32'd1);
        cycle(1'b0, 1'b1, 32'd8, 1'b1, 32'd12);
        check("both.addr", inst_addr, 32'd8);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic        st, br, jp;
            logic [31:0] bt, jt;
            st = ($urandom_range(0, 3) == 0);
            br = ($urandom_range(0, 9) == 0);
            jp = ($urandom_range(0, 9) == 0);
            bt = $urandom_range(0, 23) * 4;
            jt = $urandom_range(0, 23) * 4;
            if ($urandom_range(0, 59) == 0) bt = bt | $urandom_range(1, 3);
            if ($urandom_range(0, 59) == 0) jt = jt | $urandom_range(1, 3);
            if ($urandom_range(0, 49) == 0 || (m_halt && $urandom_range(0, 7) == 0)) begin
                do_reset();
            end else begin
                cycle(st, br, bt, jp, jt);
            end
        end

        // Misaligned jump freezes the stage until reset.
        do_reset();
        idle(); idle();
        cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0006);
        check("mis.flag", {31'd0, misalign_err}, 32'd1);
        check("mis.addr", inst_addr, 32'd8);
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, ($urandom_range(0, 1) == 1), $urandom_range(0, 15) * 4,
                  ($urandom_range(0, 1) == 1), $urandom_range(0, 15) * 4);
        end
        check("frozen.addr", inst_addr, 32'd8);
        check("frozen.valid", {31'd0, if_id_valid}, 32'd0);
        check("frozen.count", fetch_count, 32'd2);
        do_reset();
        check("post_rst.misalign", {31'd0, misalign_err}, 32'd0);
        check("post_rst.addr", inst_addr, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
